fp_divider: RTL and testbench
=============================

Name: fp_divider

Overview:
- Pipelined IEEE-754 binary32 divider computing out = a_fpn / b_fpn.
- Accepts a new operand pair every clock cycle, with a fixed latency of 2 clock edges.
- Purely datapath: no handshake and no valid signals.
- Serves as the divide unit of the FPU alongside the adder and multiplier blocks.

Parameters:
- None. Format is fixed: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a_fpn  input  32  dividend, binary32
- b_fpn  input  32  divisor, binary32
- out  output  32  quotient, binary32, registered

Behaviour:
- Single clock domain; all state updates on the rising edge of clk.
- Reset is synchronous and active-high. While rst is high at a clock edge:
  - every pipeline register clears to 0;
  - out becomes 32'h00000000.
- First valid result appears 2 edges after rst deasserts and operands are applied.
- Stage 1 (edge k), registering a_fpn and b_fpn unpacked:
  - sign = a[31] ^ b[31];
  - exponents and fractions extracted, with the hidden bit restored (1.f as 24 bits);
  - special-case flags computed: zero, inf, NaN for each operand.
- Stage 2 (edge k+1), computing and registering out:
  - 24-bit mantissa quotient via unrolled restoring division, producing 26 quotient bits plus a sticky bit (remainder != 0);
  - if quotient < 1.0, shift left by 1 and decrement the exponent;
  - exponent = ea − eb + 127, computed with ≥10-bit signed width;
  - rounding: round-to-nearest, ties-to-even, using guard bit, round bit and sticky bit;
  - mantissa carry-out on rounding increments the exponent.
- Throughput: one result per cycle. Operands changing every cycle yield results in the same order, each 2 edges after application.
- Subnormals: inputs with exponent field 0 are treated as signed zero. Results with biased exponent ≤ 0 flush to signed zero (no subnormal outputs).
- Overflow: biased exponent ≥ 255 → signed infinity {sign, 8'hFF, 23'h0}.
- Special cases, in priority order:
  - either operand NaN → 32'h7FC00000 (canonical quiet NaN);
  - 0/0 or inf/inf → 32'h7FC00000;
  - x/0 with x finite non-zero → signed infinity;
  - inf/finite → signed infinity;
  - 0/nonzero or finite/inf → signed zero.
- Zero results carry the XOR sign (e.g. −0 for −0/+5).
- Reset asserted mid-stream discards all in-flight operations. out is 0 from the reset edge until 2 edges after rst deasserts.
- No internal combinational path from inputs to out.

Test Plan:
- Reset: rst=1 for 1 cycle with a=20.0 (32'h41A00000), b=100.0 (32'h42C80000). Required: out=32'h00000000 during reset; 2 edges after release, out=32'h3E4CCCCD (0.2, rounded up).
- Back-to-back stream, one pair per cycle:
  - 20/2 (41A00000/40000000) → 32'h41200000 (10.0);
  - 18/3 (41900000/40400000) → 32'h40C00000 (6.0);
  - 20/6 (41A00000/40C00000) → 32'h40555555 (3.3333333, rounded down);
  - each result appears exactly 2 edges after its operands, in order.
- Signs and exact results:
  - −20/2 (C1A00000/40000000) → 32'hC1200000;
  - −1/−4 (BF800000/C0800000) → 32'h3E800000;
  - 1/1 → 32'h3F800000.
- Specials:
  - 1/0 → 32'h7F800000;
  - −1/0 → 32'hFF800000;
  - 0/0 → 32'h7FC00000;
  - inf/inf → 32'h7FC00000;
  - 5/inf → 32'h00000000;
  - NaN/2 → 32'h7FC00000.
- Range limits:
  - 32'h7F7FFFFF / 32'h3F000000 (max/0.5) → 32'h7F800000 (overflow);
  - 32'h00800000 / 32'h40000000 (min normal/2) → 32'h00000000 (flush to zero).
- Reset mid-stream: assert rst while 2 operations are in flight. Required: out=0 at the reset edge; no stale result emerges after release.

Source files
------------

// File: rtl/fp_divider.sv
// Two-stage pipelined IEEE-754 binary32 divider: unpack and classify, then divide, round and pack.
// Subnormal inputs read as signed zero; results that would be subnormal flush to signed zero.
module fp_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_fpn,
    input  logic [31:0] b_fpn,
    output logic [31:0] out
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic w_expZeroA, w_expMaxA, w_fracZeroA;
    logic w_expZeroB, w_expMaxB, w_fracZeroB;

    assign w_expZeroA  = (a_fpn[30:23] == 8'h00);
    assign w_expMaxA   = (a_fpn[30:23] == 8'hFF);
    assign w_fracZeroA = (a_fpn[22:0] == 23'h0);
    assign w_expZeroB  = (b_fpn[30:23] == 8'h00);
    assign w_expMaxB   = (b_fpn[30:23] == 8'hFF);
    assign w_fracZeroB = (b_fpn[22:0] == 23'h0);

    logic        r_live;
    logic        r_sign;
    logic [7:0]  r_expA, r_expB;
    logic [23:0] r_manA, r_manB;
    logic        r_zeroA, r_infA, r_nanA;
    logic        r_zeroB, r_infB, r_nanB;

    // r_live marks stage 1 as holding a real operand pair, so nothing computed from cleared registers escapes after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_live  <= 1'b0;
            r_sign  <= 1'b0;
            r_expA  <= '0;
            r_expB  <= '0;
            r_manA  <= '0;
            r_manB  <= '0;
            r_zeroA <= 1'b0;
            r_infA  <= 1'b0;
            r_nanA  <= 1'b0;
            r_zeroB <= 1'b0;
            r_infB  <= 1'b0;
            r_nanB  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_sign  <= a_fpn[31] ^ b_fpn[31];
            r_expA  <= a_fpn[30:23];
            r_expB  <= b_fpn[30:23];
            r_manA  <= {1'b1, a_fpn[22:0]};
            r_manB  <= {1'b1, b_fpn[22:0]};
            r_zeroA <= w_expZeroA;
            r_infA  <= w_expMaxA & w_fracZeroA;
            r_nanA  <= w_expMaxA & ~w_fracZeroA;
            r_zeroB <= w_expZeroB;
            r_infB  <= w_expMaxB & w_fracZeroB;
            r_nanB  <= w_expMaxB & ~w_fracZeroB;
        end
    end

    logic [25:0] w_quot;
    logic [24:0] w_rem;
    logic        w_sticky;

    // Restoring division: w_quot = floor(manA * 2^25 / manB), so bit 25 set means the quotient is >= 1.0.
    always_comb begin
        w_rem  = {1'b0, r_manA};
        w_quot = '0;
        for (int i = 25; i >= 0; i--) begin
            if (w_rem >= {1'b0, r_manB}) begin
                w_quot[i] = 1'b1;
                w_rem     = w_rem - {1'b0, r_manB};
            end
            w_rem = w_rem << 1;
        end
        w_sticky = (w_rem != '0);
    end

    logic [22:0]        w_frac;
    logic               w_guard, w_round, w_roundUp;
    logic signed [9:0]  w_expBase, w_expRnd;
    logic [32:0]        w_expFrac;
    logic [22:0]        w_fracRnd;

    always_comb begin
        if (w_quot[25]) begin
            w_frac  = w_quot[24:2];
            w_guard = w_quot[1];
            w_round = w_quot[0];
        end else begin
            w_frac  = w_quot[23:1];
            w_guard = w_quot[0];
            w_round = 1'b0;
        end
    end

    assign w_expBase = $signed({2'b00, r_expA}) - $signed({2'b00, r_expB}) + 10'sd127
                       - (w_quot[25] ? 10'sd0 : 10'sd1);
    assign w_roundUp = w_guard & (w_round | w_sticky | w_frac[0]);
    // Rounding over {exponent, fraction} lets a fraction carry-out bump the exponent for free.
    assign w_expFrac = {w_expBase, w_frac} + 33'(w_roundUp);
    assign w_expRnd  = w_expFrac[32:23];
    assign w_fracRnd = w_expFrac[22:0];

    logic [31:0] w_result;

    always_comb begin
        w_result = {r_sign, w_expRnd[7:0], w_fracRnd};
        if (!r_live)
            w_result = 32'h0;
        else if (r_nanA || r_nanB)
            w_result = QNAN;
        else if ((r_zeroA && r_zeroB) || (r_infA && r_infB))
            w_result = QNAN;
        else if (r_zeroB || r_infA)
            w_result = {r_sign, 8'hFF, 23'h0};
        else if (r_zeroA || r_infB)
            w_result = {r_sign, 31'h0};
        else if (w_expRnd >= 10'sd255)
            w_result = {r_sign, 8'hFF, 23'h0};
        else if (w_expRnd <= 10'sd0)
            w_result = {r_sign, 31'h0};
    end

    always_ff @(posedge clk) begin
        if (rst)
            out <= 32'h0;
        else
            out <= w_result;
    end
endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed spec vectors plus a randomized stream
// compared against an integer-arithmetic reference model.
module tb_fp_divider;
    logic        clk;
    logic        rst;
    logic [31:0] a_fpn;
    logic [31:0] b_fpn;
    logic [31:0] out;

    int checks = 0;
    int passed = 0;

    fp_divider dut (
        .clk   (clk),
        .rst   (rst),
        .a_fpn (a_fpn),
        .b_fpn (b_fpn),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact long division with wide integers, then round-to-nearest-even on all discarded bits.
    function automatic logic [31:0] refDivide(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        int                ea, eb, e, sh;
        bit                aNan, bNan, aInf, bInf, aZero, bZero, up;
        longint unsigned   num, q, r, mant, low, half;
        s     = a[31] ^ b[31];
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        aNan  = (ea == 255) && (a[22:0] != 0);
        bNan  = (eb == 255) && (b[22:0] != 0);
        aInf  = (ea == 255) && (a[22:0] == 0);
        bInf  = (eb == 255) && (b[22:0] == 0);
        aZero = (ea == 0);
        bZero = (eb == 0);
        if (aNan || bNan) return 32'h7FC00000;
        if ((aZero && bZero) || (aInf && bInf)) return 32'h7FC00000;
        if (bZero || aInf) return {s, 8'hFF, 23'h0};
        if (aZero || bInf) return {s, 31'h0};
        num = longint'({1'b1, a[22:0]}) << 40;
        q   = num / longint'({1'b1, b[22:0]});
        r   = num % longint'({1'b1, b[22:0]});
        e   = ea - eb + 127;
        if (q >= (64'd1 << 40)) sh = 17;
        else begin
            sh = 16;
            e  = e - 1;
        end
        mant = q >> sh;
        low  = q & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        up   = (low > half) || ((low == half) && ((r != 0) || mant[0]));
        mant = mant + (up ? 1 : 0);
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] randOperand();
        logic [7:0]  e;
        logic [22:0] f;
        int          pick;
        pick = int'($urandom_range(0, 19));
        f    = 23'($urandom);
        if (pick == 0) e = 8'h00;
        else if (pick == 1) e = 8'hFF;
        else if (pick == 2) begin
            e = 8'hFF;
            f = 23'h0;
        end else if (pick < 12) e = 8'($urandom_range(100, 154));
        else e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, f};
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        a_fpn = a;
        b_fpn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(32'h41A00000, 32'h42C80000);
        checks++;
        if (out !== 32'h0) $display("[TB] FAIL reset_out: got %h expected %h", out, 32'h0);
        else passed++;
        rst = 1'b0;
        applyStimulus(32'h41A00000, 32'h42C80000);
        checks++;
        if (out !== 32'h0) $display("[TB] FAIL reset_release1: got %h expected %h", out, 32'h0);
        else passed++;
        applyStimulus(32'h41A00000, 32'h42C80000);
        checks++;
        if (out !== 32'h3E4CCCCD) $display("[TB] FAIL reset_first_result: got %h expected %h", out, 32'h3E4CCCCD);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] opA [3];
        logic [31:0] opB [3];
        logic [31:0] want [3];
        opA  = '{32'h41A00000, 32'h41900000, 32'h41A00000};
        opB  = '{32'h40000000, 32'h40400000, 32'h40C00000};
        want = '{32'h41200000, 32'h40C00000, 32'h40555555};
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) applyStimulus(opA[i], opB[i]);
            else applyStimulus(32'h3F800000, 32'h3F800000);
            if (i > 0) begin
                checks++;
                if (out !== want[i-1])
                    $display("[TB] FAIL back_to_back[%0d]: got %h expected %h", i - 1, out, want[i-1]);
                else passed++;
            end
        end
    endtask

    task automatic test_signs();
        logic [31:0] opA [3];
        logic [31:0] opB [3];
        logic [31:0] want [3];
        opA  = '{32'hC1A00000, 32'hBF800000, 32'h3F800000};
        opB  = '{32'h40000000, 32'hC0800000, 32'h3F800000};
        want = '{32'hC1200000, 32'h3E800000, 32'h3F800000};
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) applyStimulus(opA[i], opB[i]);
            else applyStimulus(32'h3F800000, 32'h3F800000);
            if (i > 0) begin
                checks++;
                if (out !== want[i-1])
                    $display("[TB] FAIL signs[%0d]: got %h expected %h", i - 1, out, want[i-1]);
                else passed++;
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] opA [9];
        logic [31:0] opB [9];
        logic [31:0] want [9];
        opA  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000, 32'h40A00000,
                 32'h7FC00000, 32'h7F7FFFFF, 32'h00800000, 32'h80000000};
        opB  = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800000,
                 32'h40000000, 32'h3F000000, 32'h40000000, 32'h40A00000};
        want = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000,
                 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000};
        for (int i = 0; i <= 9; i++) begin
            if (i < 9) applyStimulus(opA[i], opB[i]);
            else applyStimulus(32'h3F800000, 32'h3F800000);
            if (i > 0) begin
                checks++;
                if (out !== want[i-1])
                    $display("[TB] FAIL specials[%0d]: got %h expected %h", i - 1, out, want[i-1]);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        localparam int N = 300;
        logic [31:0] want [N];
        logic [31:0] a, b;
        for (int i = 0; i <= N; i++) begin
            if (i < N) begin
                a       = randOperand();
                b       = randOperand();
                want[i] = refDivide(a, b);
                applyStimulus(a, b);
            end else applyStimulus(32'h0, 32'h3F800000);
            if (i > 0) begin
                checks++;
                if (out !== want[i-1])
                    $display("[TB] FAIL random[%0d]: got %h expected %h", i - 1, out, want[i-1]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        applyStimulus(32'h41A00000, 32'h40000000);
        applyStimulus(32'h41900000, 32'h40400000);
        checks++;
        if (out !== 32'h41200000) $display("[TB] FAIL mid_before: got %h expected %h", out, 32'h41200000);
        else passed++;
        rst = 1'b1;
        applyStimulus(32'h3F800000, 32'h3F800000);
        checks++;
        if (out !== 32'h0) $display("[TB] FAIL mid_reset_edge: got %h expected %h", out, 32'h0);
        else passed++;
        rst = 1'b0;
        applyStimulus(32'hC1A00000, 32'h40000000);
        checks++;
        if (out !== 32'h0) $display("[TB] FAIL mid_no_stale: got %h expected %h", out, 32'h0);
        else passed++;
        applyStimulus(32'hC1A00000, 32'h40000000);
        checks++;
        if (out !== 32'hC1200000) $display("[TB] FAIL mid_resume: got %h expected %h", out, 32'hC1200000);
        else passed++;
    endtask

    initial begin
        rst   = 1'b1;
        a_fpn = 32'h0;
        b_fpn = 32'h0;
        test_reset();
        test_back_to_back();
        test_signs();
        test_specials();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
